// File: rtl/vga_crt_pkg.sv
// Shared definitions for the CRT memory-read sequencer: state encoding and
// default burst / outstanding-read limits.
`timescale 1ns/1ps
package vga_crt_pkg;

  localparam int BURST_LEN_DEF = 16;
  localparam int MAX_OUT_DEF   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } crt_state_e;

endpackage

// File: rtl/crt_out_tracker.sv
// Outstanding-read counter plus drop flag that discards returns belonging to
// a burst aborted by line end.
`timescale 1ns/1ps
module crt_out_tracker (
  input  logic       mem_clk,
  input  logic       hreset,
  input  logic       ack,
  input  logic       rd_valid,
  input  logic       line_end,
  output logic [2:0] out_cnt,
  output logic       drop,
  output logic       beat_live
);

  logic [2:0] cnt_next;

  // A return with nothing outstanding is a stray and must not underflow
  assign beat_live = rd_valid & (out_cnt != 3'd0);

  always_comb begin
    cnt_next = out_cnt;
    if (ack && !beat_live)
      cnt_next = out_cnt + 3'd1;
    else if (!ack && beat_live)
      cnt_next = out_cnt - 3'd1;
  end

  always_ff @(posedge mem_clk or posedge hreset) begin
    if (hreset) begin
      out_cnt <= 3'd0;
      drop    <= 1'b0;
    end else begin
      out_cnt <= cnt_next;
      if (line_end)
        drop <= (cnt_next != 3'd0);
      else if (cnt_next == 3'd0)
        drop <= 1'b0;
    end
  end

endmodule

// File: rtl/sm_crt_mem_rsp.sv
// CRT burst read sequencer: acks CRT requests as memory commands, limits
// outstanding reads, forwards returned data to the CRT FIFO.
//   state | meaning
//   IDLE  | waiting for a CRT request
//   ISSUE | issuing reads until BURST_LEN have been accepted
//   DRAIN | waiting for the remaining data beats
//   DONE  | one-cycle data_complete, counters cleared
`timescale 1ns/1ps
module sm_crt_mem_rsp
  import vga_crt_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF,
  parameter int AW        = 21,
  parameter int DW        = 32
) (
  input  logic          mem_clk,
  input  logic          hreset,
  input  logic          sync_c_crt_line_end,
  input  logic          gra_crt_svga_req,
  input  logic [AW-1:0] crt_addr,
  output logic          svga_ack,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rd_gnt,
  input  logic          mem_rd_valid,
  input  logic [DW-1:0] mem_rd_data,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_wdata,
  output logic          data_complete
);

  localparam int ACW = $clog2(BURST_LEN) + 1;
  localparam logic [ACW-1:0] LAST_IDX  = ACW'(BURST_LEN - 1);
  localparam logic [2:0]     MAX_OUT_C = 3'(MAX_OUT);

  crt_state_e     state;
  logic [ACW-1:0] ack_cnt;
  logic [ACW-1:0] data_cnt;
  logic [2:0]     out_cnt;
  logic           drop;
  logic           beat_live;
  logic           beat_keep;

  assign mem_rd_req  = (state == ISSUE) & gra_crt_svga_req & (out_cnt < MAX_OUT_C) & ~drop;
  assign svga_ack    = mem_rd_req & mem_rd_gnt;
  assign mem_rd_addr = crt_addr;
  // A beat arriving with line end belongs to the aborted burst
  assign beat_keep   = beat_live & ~drop & ~sync_c_crt_line_end;

  crt_out_tracker u_out_tracker (
    .mem_clk   (mem_clk),
    .hreset    (hreset),
    .ack       (svga_ack),
    .rd_valid  (mem_rd_valid),
    .line_end  (sync_c_crt_line_end),
    .out_cnt   (out_cnt),
    .drop      (drop),
    .beat_live (beat_live)
  );

  always_ff @(posedge mem_clk or posedge hreset) begin
    if (hreset) begin
      state         <= IDLE;
      ack_cnt       <= '0;
      data_cnt      <= '0;
      fifo_wr       <= 1'b0;
      fifo_wdata    <= '0;
      data_complete <= 1'b0;
    end else begin
      fifo_wr       <= beat_keep;
      data_complete <= 1'b0;
      if (beat_keep)
        fifo_wdata <= mem_rd_data;
      if (sync_c_crt_line_end) begin
        state    <= IDLE;
        ack_cnt  <= '0;
        data_cnt <= '0;
      end else begin
        if (fifo_wr)
          data_cnt <= data_cnt + ACW'(1);
        case (state)
          IDLE: begin
            if (gra_crt_svga_req)
              state <= ISSUE;
          end
          ISSUE: begin
            if (svga_ack) begin
              ack_cnt <= ack_cnt + ACW'(1);
              if (ack_cnt == LAST_IDX)
                state <= DRAIN;
            end
          end
          DRAIN: begin
            if (fifo_wr && data_cnt == LAST_IDX) begin
              state         <= DONE;
              data_complete <= 1'b1;
            end
          end
          DONE: begin
            ack_cnt  <= '0;
            data_cnt <= '0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_crt_mem_rsp.sv
// Scoreboard bench for sm_crt_mem_rsp: CRT/memory model pushes expected FIFO
// data at each ack, a separate monitor pops and compares on every fifo_wr.
`timescale 1ns/1ps
module tb_sm_crt_mem_rsp;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int MAX_OUT = 4;
  localparam int BL = 16;
  localparam int GNT_OFF = 0;
  localparam int GNT_ON  = 1;
  localparam int GNT_TOG = 2;

  logic          mem_clk = 1'b0;
  logic          hreset = 1'b1;
  logic          sync_c_crt_line_end = 1'b0;
  logic          gra_crt_svga_req = 1'b0;
  logic [AW-1:0] crt_addr = 21'h00100;
  logic          svga_ack;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_gnt = 1'b0;
  logic          mem_rd_valid = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic          data_complete;

  sm_crt_mem_rsp #(.BURST_LEN(BL), .MAX_OUT(MAX_OUT), .AW(AW), .DW(DW)) dut (
    .mem_clk             (mem_clk),
    .hreset              (hreset),
    .sync_c_crt_line_end (sync_c_crt_line_end),
    .gra_crt_svga_req    (gra_crt_svga_req),
    .crt_addr            (crt_addr),
    .svga_ack            (svga_ack),
    .mem_rd_req          (mem_rd_req),
    .mem_rd_addr         (mem_rd_addr),
    .mem_rd_gnt          (mem_rd_gnt),
    .mem_rd_valid        (mem_rd_valid),
    .mem_rd_data         (mem_rd_data),
    .fifo_wr             (fifo_wr),
    .fifo_wdata          (fifo_wdata),
    .data_complete       (data_complete)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
    bit            stale;
  } beat_t;

  beat_t         mem_q[$];
  logic [DW-1:0] exp_q[$];
  int            ack_cycles[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int gnt_mode = GNT_OFF;
  int budget = 0;
  int tb_out = 0;
  int max_out = 0;
  int total_wr = 0;
  bit tb_drop = 0;
  bit real_v = 0;
  bit stray = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {11'h5a5, a};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // CRT requester and in-order memory model with fixed latency
  always begin : crt_mem
    bit acked;
    bit le_seen;
    @(negedge mem_clk);
    acked = 0;
    le_seen = 0;
    if (hreset) begin
      foreach (mem_q[i]) mem_q[i].stale = 1;
      exp_q.delete();
      tb_out = 0;
      tb_drop = 0;
    end else begin
      if (gra_crt_svga_req && !mem_rd_gnt) chk("ack_without_gnt", int'(svga_ack), 0);
      if (tb_out >= MAX_OUT) chk("out_cap", int'(mem_rd_req), 0);
      if (tb_drop) chk("cmd_while_drop", int'(mem_rd_req), 0);
      if (svga_ack) begin
        chk("rd_addr", int'(mem_rd_addr), int'(crt_addr));
        mem_q.push_back('{due: cyc + lat, d: data_of(mem_rd_addr), stale: 0});
        exp_q.push_back(data_of(crt_addr));
        ack_cycles.push_back(cyc);
        tb_out++;
        acked = 1;
      end
      if (mem_rd_valid && real_v) tb_out--;
      if (tb_out > max_out) max_out = tb_out;
      if (sync_c_crt_line_end) begin
        le_seen = 1;
        tb_drop = (tb_out > 0);
      end else if (tb_drop && tb_out == 0) begin
        tb_drop = 0;
      end
    end
    @(posedge mem_clk);
    #1;
    cyc++;
    if (le_seen) exp_q.delete();
    if (acked) begin
      crt_addr = crt_addr + 1'b1;
      budget--;
    end
    gra_crt_svga_req = (budget > 0);
    case (gnt_mode)
      GNT_ON:  mem_rd_gnt = 1'b1;
      GNT_TOG: mem_rd_gnt = ~mem_rd_gnt;
      default: mem_rd_gnt = 1'b0;
    endcase
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      beat_t b;
      b = mem_q.pop_front();
      mem_rd_valid = 1'b1;
      mem_rd_data = b.d;
      real_v = !b.stale;
    end else begin
      mem_rd_valid = stray;
      mem_rd_data = 32'hdead_beef;
      real_v = 0;
    end
  end

  // Monitor: FIFO writes against the scoreboard, data_complete after 16th write
  always begin : monitor
    int wcnt;
    bit exp_dc;
    @(negedge mem_clk);
    if (hreset) begin
      wcnt = 0;
      exp_dc = 0;
    end else begin
      if (exp_dc || data_complete) chk("data_complete", int'(data_complete), int'(exp_dc));
      exp_dc = 0;
      if (fifo_wr) begin
        total_wr++;
        if (exp_q.size() == 0) chk("unexpected_fifo_wr", 1, 0);
        else chk("fifo_wdata", int'(fifo_wdata), int'(exp_q.pop_front()));
        wcnt++;
        if (wcnt == BL) begin
          wcnt = 0;
          exp_dc = !sync_c_crt_line_end;
        end
      end
      if (sync_c_crt_line_end) wcnt = 0;
    end
  end

  task automatic start_burst(input int mode, input int l);
    @(negedge mem_clk);
    #2;
    gnt_mode = mode;
    lat = l;
    ack_cycles.delete();
    max_out = 0;
    budget = BL;
  endtask

  task automatic wait_dc(input string nm);
    bit seen = 0;
    for (int i = 0; i < 800 && !seen; i++) begin
      @(negedge mem_clk);
      #2;
      if (data_complete) seen = 1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic run_burst(input int mode, input int l, input string nm);
    int wr0;
    wr0 = total_wr;
    start_burst(mode, l);
    wait_dc({nm, "_done"});
    repeat (3) @(negedge mem_clk);
    #2;
    chk({nm, "_acks"}, ack_cycles.size(), BL);
    chk({nm, "_writes"}, total_wr - wr0, BL);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int wr0;
    repeat (3) @(negedge mem_clk);
    #1;
    chk("rst_svga_ack", int'(svga_ack), 0);
    chk("rst_mem_rd_req", int'(mem_rd_req), 0);
    chk("rst_fifo_wr", int'(fifo_wr), 0);
    chk("rst_fifo_wdata", int'(fifo_wdata), 0);
    chk("rst_data_complete", int'(data_complete), 0);
    hreset = 1'b0;

    // Stray return with nothing outstanding
    repeat (2) @(negedge mem_clk);
    stray = 1;
    @(negedge mem_clk);
    stray = 0;
    repeat (3) @(negedge mem_clk);
    chk("stray_ignored", total_wr, 0);

    run_burst(GNT_ON, 1, "zero_lat");
    if (ack_cycles.size() == BL) chk("zero_lat_ack_span", ack_cycles[BL-1] - ack_cycles[0], BL - 1);

    run_burst(GNT_ON, 10, "lat10");
    chk("lat10_max_out", max_out, MAX_OUT);

    run_burst(GNT_TOG, 2, "gnt_tog");
    if (ack_cycles.size() == BL) chk("gnt_tog_ack_span", ack_cycles[BL-1] - ack_cycles[0], 2 * (BL - 1));

    // Line end after 6 acks with 3 reads outstanding
    start_burst(GNT_ON, 3);
    for (int i = 0; i < 100 && ack_cycles.size() < 6; i++) begin
      @(negedge mem_clk);
      #2;
    end
    chk("le_six_acks", ack_cycles.size(), 6);
    gnt_mode = GNT_OFF;
    @(posedge mem_clk);
    #1;
    sync_c_crt_line_end = 1'b1;
    @(posedge mem_clk);
    #1;
    sync_c_crt_line_end = 1'b0;
    @(negedge mem_clk);
    #2;
    wr0 = total_wr;
    repeat (6) @(negedge mem_clk);
    #2;
    chk("le_dropped_writes", total_wr - wr0, 0);
    chk("le_out_drained", tb_out, 0);
    chk("le_drop_cleared", int'(tb_drop), 0);
    run_burst(GNT_ON, 3, "after_le");

    // Reset while draining
    start_burst(GNT_ON, 10);
    for (int i = 0; i < 400 && ack_cycles.size() < BL; i++) begin
      @(negedge mem_clk);
      #2;
    end
    chk("rst_drain_acks", ack_cycles.size(), BL);
    repeat (2) @(negedge mem_clk);
    #2;
    budget = 0;
    hreset = 1'b1;
    #1;
    chk("mid_rst_svga_ack", int'(svga_ack), 0);
    chk("mid_rst_mem_rd_req", int'(mem_rd_req), 0);
    chk("mid_rst_fifo_wr", int'(fifo_wr), 0);
    chk("mid_rst_fifo_wdata", int'(fifo_wdata), 0);
    chk("mid_rst_data_complete", int'(data_complete), 0);
    repeat (3) @(negedge mem_clk);
    #2;
    hreset = 1'b0;
    wr0 = total_wr;
    @(negedge mem_clk);
    stray = 1;
    @(negedge mem_clk);
    stray = 0;
    repeat (15) @(negedge mem_clk);
    #2;
    chk("post_rst_no_writes", total_wr - wr0, 0);

    run_burst(GNT_ON, 1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sm_crt_mem_rsp.md
SM_CRT_MEM_RSP -- requirements
Module: sm_crt_mem_rsp

Interface
REQ-001 Parameters (name, default, meaning): BURST_LEN, 16, CRT reads per burst (power of 2, 2..16); MAX_OUT, 4, max outstanding memory reads (1..7); AW, 21, address width; DW, 32, data width.
REQ-002 mem_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 hreset  in  1  asynchronous, active-high reset.
REQ-004 sync_c_crt_line_end  in  1  line-end abort; synchronous to mem_clk.
REQ-005 gra_crt_svga_req  in  1  CRT read request; held until acked.
REQ-006 crt_addr  in  AW  read address, valid while gra_crt_svga_req=1.
REQ-007 svga_ack  out  1  one-cycle acceptance of the current request.
REQ-008 mem_rd_req  out  1  read command to memory controller.
REQ-009 mem_rd_addr  out  AW  command address (equals crt_addr, combinational).
REQ-010 mem_rd_gnt  in  1  memory accepts command this cycle.
REQ-011 mem_rd_valid  in  1  read data beat returned (in-order).
REQ-012 mem_rd_data  in  DW  returned data.
REQ-013 fifo_wr  out  1  write strobe to CRT FIFO.
REQ-014 fifo_wdata  out  DW  CRT FIFO write data.
REQ-015 data_complete  out  1  one-cycle pulse: full burst written to FIFO.

Function
REQ-016 States: IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE -> ISSUE when gra_crt_svga_req=1; the transition cycle issues no command.
REQ-018 mem_rd_req = (state==ISSUE) & gra_crt_svga_req & (out_cnt < MAX_OUT).
REQ-019 svga_ack = mem_rd_req & mem_rd_gnt (same cycle, combinational); acks in consecutive cycles allowed.
REQ-020 Ack counter (log2(BURST_LEN)+1 bits) increments per svga_ack; ISSUE -> DRAIN on the ack making it BURST_LEN.
REQ-021 out_cnt (3 bits): +1 on svga_ack, -1 on mem_rd_valid, unchanged when both; never exceeds MAX_OUT, never below 0.
REQ-022 Data counter increments per FIFO write; fifo_wr registered: fifo_wr/fifo_wdata = mem_rd_valid/mem_rd_data delayed 1 cycle, unless dropping (REQ-026).
REQ-023 DRAIN -> DONE when data counter reaches BURST_LEN; DONE asserts data_complete for exactly one cycle, clears both counters, -> IDLE.
REQ-024 data_complete timing: cycle after the BURST_LEN-th fifo_wr.
REQ-025 Requests while in DRAIN/DONE are not acked; held request is served after IDLE.
REQ-026 sync_c_crt_line_end=1 (any state): state -> IDLE, ack and data counters -> 0, no data_complete; if out_cnt>0, drop flag set, suppressing fifo_wr until out_cnt reaches 0 (flag clears then); no new command while drop flag set.
REQ-027 Line end and mem_rd_valid in same cycle: that beat is dropped and counted in out_cnt.
REQ-028 mem_rd_valid with out_cnt==0 and no drop flag: ignored (no fifo_wr, out_cnt holds 0).

Reset
REQ-029 hreset=1 asynchronously forces: state IDLE, all counters 0, drop flag 0, fifo_wr 0, fifo_wdata 0, data_complete 0; combinational outputs svga_ack/mem_rd_req then 0.
REQ-030 Reset mid-burst discards in-flight data; after release memory returns are handled per REQ-028.

Structure
REQ-031 State encoding localparams and BURST_LEN/MAX_OUT defaults in shared package vga_crt_pkg.
REQ-032 Single module; optional sub-module crt_out_tracker (out_cnt plus drop flag).

Verification
REQ-033 Zero-latency memory (gnt=1, valid 1 cycle after gnt): 16 acks in 16 consecutive cycles, 16 fifo_wr, data_complete 1 cycle after 16th write.
REQ-034 gnt=1, read latency 10: mem_rd_req drops after 4 outstanding; never 5; burst completes with 16 writes in order.
REQ-035 gnt toggling 1/0: ack only on gnt=1 cycles; fifo_wdata sequence equals issued order 0..15.
REQ-036 Line end after 6 acks with 3 outstanding: state IDLE, 3 returns produce no fifo_wr, no data_complete; next burst gives exactly 16 writes.
REQ-037 hreset mid-DRAIN: all outputs 0 immediately; stray mem_rd_valid after release produces no fifo_wr.
